// File: rtl/sparvec_mul_sched_if.sv
// Handshake and memory-port bundle between the sparse-vector multiply sequencer and its neighbours.
interface sparvec_mul_sched_if #(
  parameter int unsigned AW        = 5,
  parameter int unsigned PROC_SIZE = 64
);
  logic                 i_start;
  logic                 i_preload_en;
  logic                 i_abort;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_pre_rd;
  logic [AW-1:0]        o_pre_addr;
  logic [PROC_SIZE-1:0] i_pre_data;
  logic                 o_vec_add_wen;
  logic [AW-1:0]        o_vec_add_addr;
  logic [PROC_SIZE-1:0] o_vec_add;
  logic                 o_mul_start;
  logic                 i_mul_done;
  logic                 o_res_en;
  logic [AW-1:0]        o_res_addr;
  logic [PROC_SIZE-1:0] i_res;
  logic [PROC_SIZE-1:0] o_res_data;
  logic                 o_res_valid;
  logic                 o_res_last;
  logic                 i_res_ready;

  // Sequencer side
  modport master (
    input  i_start, i_preload_en, i_abort, i_pre_data, i_mul_done, i_res, i_res_ready,
    output o_busy, o_done, o_pre_rd, o_pre_addr, o_vec_add_wen, o_vec_add_addr, o_vec_add,
           o_mul_start, o_res_en, o_res_addr, o_res_data, o_res_valid, o_res_last
  );

  // Environment side (protocol FSM, preload source, multiplier, stream sink)
  modport slave (
    output i_start, i_preload_en, i_abort, i_pre_data, i_mul_done, i_res, i_res_ready,
    input  o_busy, o_done, o_pre_rd, o_pre_addr, o_vec_add_wen, o_vec_add_addr, o_vec_add,
           o_mul_start, o_res_en, o_res_addr, o_res_data, o_res_valid, o_res_last
  );
endinterface

// File: rtl/sparvec_mul_sched.sv
// Job sequencer for the sparse matrix x sparse-vector GF(256) multiplier:
// init/preload result memory, run the multiplier, drain results as a stream.
module sparvec_mul_sched #(
  parameter string PARAMETER_SET = "L3"
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  sparvec_mul_sched_if.master  bus
);
  localparam int unsigned MAT_ROW_SIZE_BYTES = (PARAMETER_SET == "L1") ? 104 :
                                               (PARAMETER_SET == "L2") ? 159 :
                                               (PARAMETER_SET == "L3") ? 202 : 8;
  localparam int unsigned N_GF      = 8;
  localparam int unsigned PROC_SIZE = N_GF * 8;
  localparam int unsigned RES_WORDS = MAT_ROW_SIZE_BYTES / N_GF;
  localparam int unsigned AW        = (RES_WORDS > 1) ? $clog2(RES_WORDS) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(RES_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_START, S_WAIT_MUL, S_DRAIN, S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic                 preload_q, preload_d;
  logic                 mul_pend_q, mul_pend_d;   // multiplier started, done not yet seen
  logic                 pre_act_q, pre_act_d;     // preload reads still to issue
  logic [AW-1:0]        pre_addr_q, pre_addr_d;
  logic                 wr_vld_q, wr_vld_d;       // a read was issued last cycle -> write now
  logic [AW-1:0]        wr_addr_q, wr_addr_d;
  logic                 rd_left_q, rd_left_d;     // result reads still to issue
  logic [AW-1:0]        rd_addr_q, rd_addr_d;
  logic                 inflight_q, inflight_d;
  logic [AW-1:0]        out_idx_q, out_idx_d;
  logic [PROC_SIZE-1:0] fifo_q [2];
  logic [PROC_SIZE-1:0] fifo_d [2];
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic [1:0]           count_q, count_d;

  logic                 res_valid_c;
  logic                 res_last_c;
  logic                 pop_c;
  logic                 issue_c;

  // Stream handshake and read-issue decision; occupancy counts this cycle's departure
  always_comb begin
    res_valid_c = (count_q != 2'd0);
    res_last_c  = res_valid_c && (out_idx_q == LAST_ADDR);
    pop_c       = res_valid_c && bus.i_res_ready;
    issue_c     = (state_q == S_DRAIN) && rd_left_q &&
                  ((3'(count_q) + 3'(inflight_q) - 3'(pop_c)) < 3'd2);
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    preload_d  = preload_q;
    mul_pend_d = mul_pend_q;
    pre_act_d  = pre_act_q;
    pre_addr_d = pre_addr_q;
    wr_vld_d   = wr_vld_q;
    wr_addr_d  = wr_addr_q;
    rd_left_d  = rd_left_q;
    rd_addr_d  = rd_addr_q;
    inflight_d = inflight_q;
    out_idx_d  = out_idx_q;
    fifo_d     = fifo_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (bus.i_mul_done) mul_pend_d = 1'b0;
    if (state_q == S_START) mul_pend_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          state_d    = S_INIT;
          preload_d  = bus.i_preload_en;
          pre_act_d  = 1'b1;
          pre_addr_d = '0;
          wr_vld_d   = 1'b0;
        end
      end
      S_INIT: begin
        wr_vld_d  = pre_act_q;
        wr_addr_d = pre_addr_q;
        if (pre_act_q) begin
          if (pre_addr_q == LAST_ADDR) pre_act_d  = 1'b0;
          else                         pre_addr_d = pre_addr_q + AW'(1);
        end else if (!mul_pend_q) begin
          // an aborted multiplier run must report done before a restart
          state_d = S_START;
        end
      end
      S_START: begin
        state_d = S_WAIT_MUL;
      end
      S_WAIT_MUL: begin
        if (bus.i_mul_done) begin
          state_d    = S_DRAIN;
          rd_left_d  = 1'b1;
          rd_addr_d  = '0;
          inflight_d = 1'b0;
          out_idx_d  = '0;
          count_d    = 2'd0;
          rd_ptr_d   = 1'b0;
          wr_ptr_d   = 1'b0;
        end
      end
      S_DRAIN: begin
        inflight_d = issue_c;
        if (issue_c) begin
          if (rd_addr_q == LAST_ADDR) rd_left_d = 1'b0;
          else                        rd_addr_d = rd_addr_q + AW'(1);
        end
        if (inflight_q) begin
          fifo_d[wr_ptr_q] = bus.i_res;
          wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop_c) begin
          rd_ptr_d = ~rd_ptr_q;
          if (out_idx_q != LAST_ADDR) out_idx_d = out_idx_q + AW'(1);
        end
        count_d = count_q + 2'(inflight_q) - 2'(pop_c);
        if (pop_c && res_last_c) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort flushes everything except knowledge of a still-running multiplier
    if (bus.i_abort) begin
      state_d    = S_IDLE;
      pre_act_d  = 1'b0;
      wr_vld_d   = 1'b0;
      rd_left_d  = 1'b0;
      inflight_d = 1'b0;
      count_d    = 2'd0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      preload_q  <= 1'b0;
      mul_pend_q <= 1'b0;
      pre_act_q  <= 1'b0;
      pre_addr_q <= '0;
      wr_vld_q   <= 1'b0;
      wr_addr_q  <= '0;
      rd_left_q  <= 1'b0;
      rd_addr_q  <= '0;
      inflight_q <= 1'b0;
      out_idx_q  <= '0;
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      preload_q  <= preload_d;
      mul_pend_q <= mul_pend_d;
      pre_act_q  <= pre_act_d;
      pre_addr_q <= pre_addr_d;
      wr_vld_q   <= wr_vld_d;
      wr_addr_q  <= wr_addr_d;
      rd_left_q  <= rd_left_d;
      rd_addr_q  <= rd_addr_d;
      inflight_q <= inflight_d;
      out_idx_q  <= out_idx_d;
      for (int i = 0; i < 2; i++) fifo_q[i] <= fifo_d[i];
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Output decode from registered state; preload data passes straight to the write port
  assign bus.o_busy         = (state_q != S_IDLE);
  assign bus.o_done         = (state_q == S_DONE);
  assign bus.o_pre_rd       = (state_q == S_INIT) && pre_act_q && preload_q;
  assign bus.o_pre_addr     = ((state_q == S_INIT) && pre_act_q) ? pre_addr_q : '0;
  assign bus.o_vec_add_wen  = (state_q == S_INIT) && wr_vld_q;
  assign bus.o_vec_add_addr = bus.o_vec_add_wen ? wr_addr_q : '0;
  assign bus.o_vec_add      = (bus.o_vec_add_wen && preload_q) ? bus.i_pre_data : '0;
  assign bus.o_mul_start    = (state_q == S_START);
  assign bus.o_res_en       = (state_q == S_DRAIN);
  assign bus.o_res_addr     = (state_q == S_DRAIN) ? rd_addr_q : '0;
  assign bus.o_res_data     = res_valid_c ? fifo_q[rd_ptr_q] : '0;
  assign bus.o_res_valid    = res_valid_c;
  assign bus.o_res_last     = res_last_c;

endmodule

// File: tb/tb_sparvec_mul_sched.sv
// Randomized bench for sparvec_mul_sched (L1 set) with preload source, result memory,
// multiplier and stream sink models.
module tb_sparvec_mul_sched;
  localparam int unsigned RES_WORDS = 13;
  localparam int unsigned AW        = 4;
  localparam int unsigned PW        = 64;

  logic i_clk;
  logic i_rst_n;

  sparvec_mul_sched_if #(.AW(AW), .PROC_SIZE(PW)) bus ();

  sparvec_mul_sched #(.PARAMETER_SET("L1")) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks;
  int n_pass;
  int cyc;

  logic [PW-1:0] src     [16];
  logic [PW-1:0] contrib [16];
  logic [PW-1:0] res_mem [16];

  int            wr_addr_q [$];
  logic [PW-1:0] wr_data_q [$];
  logic [PW-1:0] str_data_q[$];
  bit            str_last_q[$];

  int n_start, n_done, n_pre_rd, start_cyc, first_vld_cyc, last_xfer_cyc, restart_viol;
  int mul_cnt, mul_delay;
  bit mul_apply, next_apply, spur_req;
  bit stall_prev, stall_last;
  logic [PW-1:0] stall_data;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic bit any_out();
    return bus.o_busy | bus.o_done | bus.o_pre_rd | (|bus.o_pre_addr) | bus.o_vec_add_wen |
           (|bus.o_vec_add_addr) | (|bus.o_vec_add) | bus.o_mul_start | bus.o_res_en |
           (|bus.o_res_addr) | (|bus.o_res_data) | bus.o_res_valid | bus.o_res_last;
  endfunction

  // One clock: observe the current cycle, advance, then let the environment models respond
  task automatic step();
    logic          rd;
    logic [AW-1:0] ra;
    logic [AW-1:0] qa;
    rd = bus.o_pre_rd;
    ra = bus.o_pre_addr;
    qa = bus.o_res_addr;
    if (rd) n_pre_rd++;
    if (bus.o_vec_add_wen) begin
      res_mem[bus.o_vec_add_addr] = bus.o_vec_add;
      wr_addr_q.push_back(int'(bus.o_vec_add_addr));
      wr_data_q.push_back(bus.o_vec_add);
    end
    if (bus.o_mul_start) begin
      if (mul_cnt > 0) restart_viol++;
      n_start++;
      start_cyc = cyc;
      mul_cnt   = mul_delay;
      mul_apply = next_apply;
    end
    if (bus.o_done) n_done++;
    if (stall_prev) begin
      check_eq("stall_valid", 64'(bus.o_res_valid), 64'd1);
      check_eq("stall_data", bus.o_res_data, stall_data);
      check_eq("stall_last", 64'(bus.o_res_last), 64'(stall_last));
      stall_prev = 1'b0;
    end
    if (bus.o_res_valid) begin
      if (first_vld_cyc < 0) first_vld_cyc = cyc;
      if (bus.i_res_ready) begin
        str_data_q.push_back(bus.o_res_data);
        str_last_q.push_back(bus.o_res_last);
        last_xfer_cyc = cyc;
      end else begin
        stall_prev = 1'b1;
        stall_data = bus.o_res_data;
        stall_last = bus.o_res_last;
      end
    end
    @(posedge i_clk);
    #1;
    cyc++;
    bus.i_pre_data = rd ? src[ra] : '0;
    bus.i_res      = res_mem[qa];
    bus.i_mul_done = spur_req;
    spur_req       = 1'b0;
    if (mul_cnt > 0) begin
      mul_cnt--;
      if (mul_cnt == 0) begin
        bus.i_mul_done = 1'b1;
        if (mul_apply)
          for (int k = 0; k < int'(RES_WORDS); k++) res_mem[k] = res_mem[k] ^ contrib[k];
      end
    end
    #1;
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    str_data_q.delete();
    str_last_q.delete();
    n_start = 0; n_done = 0; n_pre_rd = 0;
    start_cyc = -1; first_vld_cyc = -1; last_xfer_cyc = -1;
    stall_prev = 1'b0;
  endtask

  // Full job; clean=1 means no multiplier left running from an earlier aborted job
  task automatic run_job(input bit pre, input int rmode, input bit incr_src, input bit clean);
    int            t0;
    int            lim;
    bit            spur_drain;
    logic [PW-1:0] exp_w;
    for (int k = 0; k < 16; k++) begin
      src[k]     = incr_src ? {8{8'(k)}} : {$urandom, $urandom};
      contrib[k] = {$urandom, $urandom};
    end
    clear_logs();
    next_apply = 1'b1;
    mul_delay  = $urandom_range(9, 2);
    if (clean) begin
      spur_req = 1'b1;
      step();
      step();
      check_eq("idle_spur_busy", 64'(bus.o_busy), 64'd0);
      check_eq("idle_spur_start", 64'(n_start), 64'd0);
    end
    bus.i_preload_en = pre;
    bus.i_start      = 1'b1;
    t0 = cyc;
    step();
    bus.i_start      = 1'b0;
    bus.i_preload_en = ~pre;
    check_eq("busy_after_start", 64'(bus.o_busy), 64'd1);
    step();
    if (clean) spur_req = 1'b1;
    step();
    lim = 0;
    spur_drain = 1'b0;
    while (!(n_done > 0 && !bus.o_busy) && lim < 500) begin
      case (rmode)
        0:       bus.i_res_ready = 1'b1;
        1:       bus.i_res_ready = (lim % 3 == 0);
        default: bus.i_res_ready = 1'($urandom_range(1, 0));
      endcase
      if (clean && bus.o_res_en && !spur_drain) begin
        spur_req   = 1'b1;
        spur_drain = 1'b1;
      end
      step();
      lim++;
    end
    bus.i_res_ready = 1'b1;
    check_eq("job_finished", 64'(lim < 500), 64'd1);
    check_eq("n_writes", 64'(wr_addr_q.size()), 64'(RES_WORDS));
    for (int k = 0; k < wr_addr_q.size() && k < int'(RES_WORDS); k++) begin
      check_eq("wr_addr", 64'(wr_addr_q[k]), 64'(k));
      check_eq("wr_data", wr_data_q[k], pre ? src[k] : 64'd0);
    end
    check_eq("n_pre_rd", 64'(n_pre_rd), pre ? 64'(RES_WORDS) : 64'd0);
    check_eq("n_mul_start", 64'(n_start), 64'd1);
    if (clean) check_eq("start_latency", 64'(start_cyc - t0), 64'(RES_WORDS + 2));
    check_eq("n_words", 64'(str_data_q.size()), 64'(RES_WORDS));
    for (int k = 0; k < str_data_q.size() && k < int'(RES_WORDS); k++) begin
      exp_w = (pre ? src[k] : 64'd0) ^ contrib[k];
      check_eq("word_data", str_data_q[k], exp_w);
      check_eq("word_last", 64'(str_last_q[k]), 64'(k == int'(RES_WORDS) - 1));
    end
    check_eq("n_done", 64'(n_done), 64'd1);
    if (rmode == 0) check_eq("stream_rate", 64'(last_xfer_cyc - first_vld_cyc), 64'(RES_WORDS - 1));
  endtask

  // phase 0: INIT, 1: WAIT_MUL, 2: DRAIN
  task automatic abort_job(input int phase);
    int lim;
    clear_logs();
    next_apply = 1'b1;
    mul_delay  = (phase == 1) ? 40 : 6;
    bus.i_res_ready  = 1'b1;
    bus.i_preload_en = 1'b1;
    bus.i_start      = 1'b1;
    step();
    bus.i_start = 1'b0;
    lim = 0;
    case (phase)
      0: repeat (4) step();
      1: begin
        while (n_start == 0 && lim < 100) begin step(); lim++; end
        step();
      end
      default: begin
        while (!bus.o_res_valid && lim < 200) begin step(); lim++; end
        step();
        step();
      end
    endcase
    check_eq("abort_reach", 64'(lim < 100), 64'd1);
    check_eq("abort_busy_before", 64'(bus.o_busy), 64'd1);
    bus.i_abort = 1'b1;
    step();
    bus.i_abort = 1'b0;
    if (phase == 1) mul_apply = 1'b0;
    check_eq("abort_busy", 64'(bus.o_busy), 64'd0);
    check_eq("abort_wen", 64'(bus.o_vec_add_wen), 64'd0);
    check_eq("abort_mul_start", 64'(bus.o_mul_start), 64'd0);
    check_eq("abort_res_en", 64'(bus.o_res_en), 64'd0);
    check_eq("abort_valid", 64'(bus.o_res_valid), 64'd0);
    repeat (3) step();
    check_eq("abort_no_done", 64'(n_done), 64'd0);
  endtask

  initial begin
    int lim;
    n_checks = 0; n_pass = 0; cyc = 0; restart_viol = 0;
    mul_cnt = 0; mul_delay = 4; mul_apply = 1'b0; next_apply = 1'b0; spur_req = 1'b0;
    stall_prev = 1'b0; stall_last = 1'b0; stall_data = '0;
    for (int k = 0; k < 16; k++) begin src[k] = '0; contrib[k] = '0; res_mem[k] = '0; end
    bus.i_start = 1'b0; bus.i_preload_en = 1'b0; bus.i_abort = 1'b0;
    bus.i_pre_data = '0; bus.i_mul_done = 1'b0; bus.i_res = '0; bus.i_res_ready = 1'b1;
    i_rst_n = 1'b0;
    #12;
    check_eq("rst_outputs_low", 64'(any_out()), 64'd0);
    #10;
    i_rst_n = 1'b1;
    step();
    check_eq("post_rst_outputs", 64'(any_out()), 64'd0);

    run_job(1'b1, 0, 1'b1, 1'b1);
    run_job(1'b0, 0, 1'b0, 1'b1);
    run_job(1'b1, 1, 1'b0, 1'b1);
    run_job(1'b0, 2, 1'b0, 1'b1);
    abort_job(0);
    run_job(1'b1, 2, 1'b0, 1'b1);
    abort_job(1);
    run_job(1'b1, 0, 1'b0, 1'b0);
    abort_job(2);
    run_job(1'b0, 1, 1'b0, 1'b1);

    // asynchronous reset while a stalled word sits in the output buffer
    clear_logs();
    next_apply = 1'b1;
    mul_delay  = 3;
    bus.i_res_ready  = 1'b0;
    bus.i_preload_en = 1'b1;
    bus.i_start      = 1'b1;
    step();
    bus.i_start = 1'b0;
    lim = 0;
    while (!bus.o_res_valid && lim < 200) begin step(); lim++; end
    step();
    check_eq("rst_reach_drain", 64'(bus.o_res_valid), 64'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_eq("midjob_rst_outputs", 64'(any_out()), 64'd0);
    stall_prev = 1'b0;
    @(posedge i_clk);
    #3;
    i_rst_n = 1'b1;
    bus.i_res_ready = 1'b1;
    step();
    check_eq("rst_fifo_empty", 64'(bus.o_res_valid), 64'd0);
    check_eq("rst_idle", 64'(bus.o_busy), 64'd0);
    run_job(1'b1, 0, 1'b0, 1'b1);

    check_eq("no_early_restart", 64'(restart_viol), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
